// File: rtl/tri_bus_arbiter.sv
// rtl/tri_bus_arbiter.sv - round-robin owner of a shared tri-state bus with hold limit.
// Define TRI_BUS_TURNAROUND_EN to insert one undriven TURN cycle between owners.
module tri_bus_arbiter #(
  parameter int NREQ    = 4,
  parameter int WIDTH   = 2,
  parameter int MAXHOLD = 8
) (
  input  logic                    Clk,
  input  logic                    Reset,
  input  logic [NREQ-1:0]         Req,
  input  logic [NREQ*WIDTH-1:0]   Data,
  output logic [NREQ-1:0]         Gnt,
  output logic                    OE,
  inout  tri   [WIDTH-1:0]        Bus,
  output logic                    Busy
);

  localparam int         IW   = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam logic [7:0] MAXH = 8'(MAXHOLD);

  typedef enum logic [1:0] {IDLE, OWN, TURN} state_t;

  state_t          state_q, state_d;
  logic [NREQ-1:0] gnt_q, gnt_d;
  logic [IW-1:0]   own_q, own_d;
  logic [IW-1:0]   last_q, last_d;
  logic [7:0]      hold_cnt_q, hold_cnt_d;

  logic [IW-1:0]   base;
  logic [IW-1:0]   win;
  logic            found;
  logic            others;
  logic            release_c;
  logic [WIDTH-1:0] own_data;

  // While owning, the search starts after the current owner so a forced
  // release never hands the bus straight back to it.
  always_comb begin
    base  = (state_q == OWN) ? own_q : last_q;
    found = 1'b0;
    win   = '0;
    for (int k = 1; k <= NREQ; k++) begin
      if (!found && Req[(int'(base) + k) % NREQ]) begin
        found = 1'b1;
        win   = IW'((int'(base) + k) % NREQ);
      end
    end
  end

  assign others    = |(Req & ~gnt_q);
  assign release_c = !Req[own_q] || ((hold_cnt_q == MAXH) && others);
  assign own_data  = Data[int'(own_q)*WIDTH +: WIDTH];

  always_comb begin
    state_d    = state_q;
    gnt_d      = gnt_q;
    own_d      = own_q;
    last_d     = last_q;
    hold_cnt_d = hold_cnt_q;
    case (state_q)
      IDLE, TURN: begin
        if (found) begin
          state_d    = OWN;
          own_d      = win;
          gnt_d      = '0;
          gnt_d[win] = 1'b1;
          hold_cnt_d = 8'd1;
        end else begin
          state_d    = IDLE;
          gnt_d      = '0;
          hold_cnt_d = 8'd0;
        end
      end
      OWN: begin
        if (release_c) begin
          last_d = own_q;
`ifdef TRI_BUS_TURNAROUND_EN
          state_d    = TURN;
          gnt_d      = '0;
          hold_cnt_d = 8'd0;
`else
          if (found) begin
            state_d    = OWN;
            own_d      = win;
            gnt_d      = '0;
            gnt_d[win] = 1'b1;
            hold_cnt_d = 8'd1;
          end else begin
            state_d    = IDLE;
            gnt_d      = '0;
            hold_cnt_d = 8'd0;
          end
`endif
        end else if (hold_cnt_q != MAXH) begin
          hold_cnt_d = hold_cnt_q + 8'd1;
        end
      end
      default: begin
        state_d    = IDLE;
        gnt_d      = '0;
        hold_cnt_d = 8'd0;
      end
    endcase
  end

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state_q    <= IDLE;
      gnt_q      <= '0;
      own_q      <= '0;
      last_q     <= IW'(NREQ - 1);
      hold_cnt_q <= 8'd0;
    end else begin
      state_q    <= state_d;
      gnt_q      <= gnt_d;
      own_q      <= own_d;
      last_q     <= last_d;
      hold_cnt_q <= hold_cnt_d;
    end
  end

  // OE follows the state flop directly, so reset floats the bus at once.
  assign Gnt  = gnt_q;
  assign OE   = (state_q == OWN);
  assign Busy = (state_q == OWN) || (state_q == TURN);
  assign Bus  = OE ? own_data : {WIDTH{1'bz}};

endmodule
